// File: rtl/tcam_pkg.sv
// tcam_pkg -- shared declarations for the TCAM update path.
//
// Contents:
//   tcam_state_e  : update sequencer FSM state encoding (IDLE, SHIFT, DONE)
//   calc_blk_w()  : block-index width, max(1, clog2(NUM_BLOCKS))
//   calc_idx_w()  : shift-index width, clog2(SRL_DEPTH)
package tcam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tcam_state_e;

    function automatic int calc_blk_w(input int num_blocks);
        return (num_blocks <= 2) ? 1 : $clog2(num_blocks);
    endfunction

    function automatic int calc_idx_w(input int srl_depth);
        return $clog2(srl_depth);
    endfunction

endpackage

// File: rtl/tcam_onehot_dec.sv
// tcam_onehot_dec -- decodes a block index into a one-hot block mask.
//
// Ports:
//   blk   in  BLK_W       block index
//   mask  out NUM_BLOCKS  one-hot mask, all zero when blk is out of range
//   oor   out 1           blk >= NUM_BLOCKS
module tcam_onehot_dec #(
    parameter int NUM_BLOCKS = 8,
    parameter int BLK_W      = 3
) (
    input  logic [BLK_W-1:0]      blk,
    output logic [NUM_BLOCKS-1:0] mask,
    output logic                  oor
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            mask[i] = (blk == BLK_W'(i));
        end
    end

    // Only reachable when NUM_BLOCKS is not a power of two.
    assign oor = (int'(blk) >= NUM_BLOCKS);

endmodule

// File: rtl/tcam_update_ctrl.sv
// tcam_update_ctrl -- update sequencer for the SRL-based TCAM array.
//
// Accepts one block-update request, drives that block's SRL clock-enable
// for SRL_DEPTH shift cycles while presenting the bit index being shifted,
// then pulses we_block (on the last shift cycle) and upd_done. Search-path
// CE requests (ce_demux) are OR-ed onto the CE lines combinationally.
//
// Optional feature: define TCAM_UPD_BCAST_EN to honour upd_bcast
// (update every block at once, never rejected).
//
// Handshake: a request transfers on a rising clk edge where
// upd_valid & upd_ready. upd_ready is high only in IDLE and outside reset;
// a requester must hold upd_valid/upd_blk until the transfer, so requests
// presented during SHIFT/DONE are stalled, never dropped.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   upd_valid    in   update request
//   upd_ready    out  request accepted when upd_valid & upd_ready
//   upd_blk      in   target block index
//   upd_bcast    in   broadcast update (TCAM_UPD_BCAST_EN only)
//   ce_demux     in   search-path CE requests
//   ce           out  SRL clock-enables
//   shift_idx    out  bit index being shifted
//   busy         out  sequencer not idle
//   we_block     out  commit pulse on the final shift cycle
//   upd_done     out  completion pulse
//   upd_err      out  registered pulse for a rejected request
//   state_dbg    out  current FSM state
module tcam_update_ctrl
    import tcam_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    parameter  int SRL_DEPTH  = 32,
    localparam int BLK_W      = calc_blk_w(NUM_BLOCKS),
    localparam int IDX_W      = calc_idx_w(SRL_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [BLK_W-1:0]      upd_blk,
    input  logic                  upd_bcast,
    input  logic [NUM_BLOCKS-1:0] ce_demux,
    output logic [NUM_BLOCKS-1:0] ce,
    output logic [IDX_W-1:0]      shift_idx,
    output logic                  busy,
    output logic                  we_block,
    output logic                  upd_done,
    output logic                  upd_err,
    output tcam_state_e           state_dbg
);

    tcam_state_e           state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [NUM_BLOCKS-1:0] mask_q, mask_d;
    logic                  err_q, err_d;

    logic [NUM_BLOCKS-1:0] dec_mask;
    logic                  dec_oor;
    logic                  bcast;
    logic                  handshake;
    logic                  last_shift;

`ifdef TCAM_UPD_BCAST_EN
    assign bcast = upd_bcast;
`else
    logic unused_bcast;
    assign unused_bcast = upd_bcast;
    assign bcast        = 1'b0;
`endif

    tcam_onehot_dec #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLK_W      (BLK_W)
    ) u_dec (
        .blk  (upd_blk),
        .mask (dec_mask),
        .oor  (dec_oor)
    );

    assign handshake  = upd_valid & upd_ready;
    assign last_shift = (cnt_q == IDX_W'(SRL_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (bcast) begin
                        mask_d  = '1;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else if (!dec_oor) begin
                        mask_d  = dec_mask;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // Leave SHIFT on the last index so the counter never wraps.
                if (last_shift) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are qualified with !rst so an update aborted by reset never
    // drives its CE lines or commits during the reset cycle itself.
    assign upd_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign we_block  = (state_q == ST_SHIFT) & last_shift & ~rst;
    assign upd_done  = (state_q == ST_DONE) & ~rst;
    assign upd_err   = err_q;
    assign shift_idx = cnt_q;
    assign ce        = ce_demux | (mask_q & {NUM_BLOCKS{(state_q == ST_SHIFT) & ~rst}});
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tcam_update_ctrl.sv
module tb_tcam_update_ctrl;
    import tcam_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // 8 blocks x 32 deep
    logic       upd_valid8 = 1'b0;
    logic       upd_ready8;
    logic [2:0] upd_blk8 = '0;
    logic       upd_bcast8 = 1'b0;
    logic [7:0] ce_demux8 = '0;
    logic [7:0] ce8;
    logic [4:0] shift_idx8;
    logic       busy8, we_block8, upd_done8, upd_err8;
    tcam_state_e state8;

    // 6 blocks x 32 deep (out-of-range indices exist)
    logic       upd_valid6 = 1'b0;
    logic       upd_ready6;
    logic [2:0] upd_blk6 = '0;
    logic       upd_bcast6 = 1'b0;
    logic [5:0] ce_demux6 = '0;
    logic [5:0] ce6;
    logic [4:0] shift_idx6;
    logic       busy6, we_block6, upd_done6, upd_err6;
    tcam_state_e state6;

    tcam_update_ctrl #(.NUM_BLOCKS(8), .SRL_DEPTH(32)) dut8 (
        .clk(clk), .rst(rst), .upd_valid(upd_valid8), .upd_ready(upd_ready8),
        .upd_blk(upd_blk8), .upd_bcast(upd_bcast8), .ce_demux(ce_demux8), .ce(ce8),
        .shift_idx(shift_idx8), .busy(busy8), .we_block(we_block8),
        .upd_done(upd_done8), .upd_err(upd_err8), .state_dbg(state8)
    );

    tcam_update_ctrl #(.NUM_BLOCKS(6), .SRL_DEPTH(32)) dut6 (
        .clk(clk), .rst(rst), .upd_valid(upd_valid6), .upd_ready(upd_ready6),
        .upd_blk(upd_blk6), .upd_bcast(upd_bcast6), .ce_demux(ce_demux6), .ce(ce6),
        .shift_idx(shift_idx6), .busy(busy6), .we_block(we_block6),
        .upd_done(upd_done6), .upd_err(upd_err6), .state_dbg(state6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Land 2 time units after the rising edge: inputs set here are sampled
    // at the next edge; outputs are checked after a further #1.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at the start of handshake cycle T. With hold_next, upd_valid
    // stays high and upd_blk switches to next_blk (ignored while busy).
    task automatic do_update8(input int blk, input logic [7:0] dmx,
                              input bit hold_next, input int next_blk);
        logic [7:0] m;
        m = 8'd1 << blk;
        ce_demux8  = dmx;
        upd_valid8 = 1'b1;
        upd_blk8   = 3'(blk);
        #1;
        check("ready_at_T", 32'(upd_ready8), 32'd1);
        check("ce_idle", 32'(ce8), 32'(dmx));
        step();
        if (hold_next) upd_blk8 = 3'(next_blk);
        else           upd_valid8 = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            check("ce_shift", 32'(ce8), 32'(dmx | m));
            check("shift_idx", 32'(shift_idx8), 32'(k));
            check("we_block_shift", 32'(we_block8), (k == 31) ? 32'd1 : 32'd0);
            check("ready_shift", 32'(upd_ready8), 32'd0);
            check("busy_shift", 32'(busy8), 32'd1);
            step();
            #1;
        end
        check("done_pulse", 32'(upd_done8), 32'd1);
        check("ce_done", 32'(ce8), 32'(dmx));
        check("we_done", 32'(we_block8), 32'd0);
        check("ready_done", 32'(upd_ready8), 32'd0);
        step();
        #1;
        check("ready_T34", 32'(upd_ready8), 32'd1);
        check("done_T34", 32'(upd_done8), 32'd0);
        check("busy_T34", 32'(busy8), 32'd0);
    endtask

    initial begin
        // Reset state
        rst       = 1'b1;
        ce_demux8 = 8'h5a;
        ce_demux6 = 6'h21;
        step(); step();
        #1;
        check("rst_ready", 32'(upd_ready8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_we", 32'(we_block8), 32'd0);
        check("rst_done", 32'(upd_done8), 32'd0);
        check("rst_err", 32'(upd_err8), 32'd0);
        check("rst_idx", 32'(shift_idx8), 32'd0);
        check("rst_ce", 32'(ce8), 32'h5a);
        check("rst_ce6", 32'(ce6), 32'h21);
        rst = 1'b0;
        ce_demux6 = '0;
        #1;
        check("ready_after_rst", 32'(upd_ready8), 32'd1);
        step();

        // Single update of block 3, no search traffic
        do_update8(3, 8'h00, 1'b0, 0);
        // Search merge during update of block 3
        do_update8(3, 8'h81, 1'b0, 0);
        // Back-to-back: blk 1 then blk 6 with upd_valid held
        do_update8(1, 8'h00, 1'b1, 6);
        do_update8(6, 8'h00, 1'b0, 0);
        ce_demux8 = 8'h00;

        // Out-of-range on the 6-block instance
        upd_valid6 = 1'b1;
        upd_blk6   = 3'd7;
        #1;
        check("oor_ready", 32'(upd_ready6), 32'd1);
        step();
        upd_valid6 = 1'b0;
        #1;
        check("oor_err", 32'(upd_err6), 32'd1);
        check("oor_busy", 32'(busy6), 32'd0);
        check("oor_ce", 32'(ce6), 32'd0);
        check("oor_we", 32'(we_block6), 32'd0);
        step();
        #1;
        check("oor_err_clear", 32'(upd_err6), 32'd0);
        check("oor_busy2", 32'(busy6), 32'd0);

        // Broadcast request, blk out of range
        upd_valid6 = 1'b1;
        upd_bcast6 = 1'b1;
        upd_blk6   = 3'd7;
        step();
        upd_valid6 = 1'b0;
        upd_bcast6 = 1'b0;
        #1;
`ifdef TCAM_UPD_BCAST_EN
        for (int k = 0; k < 32; k++) begin
            check("bc_ce", 32'(ce6), 32'h3f);
            check("bc_err", 32'(upd_err6), 32'd0);
            check("bc_idx", 32'(shift_idx6), 32'(k));
            check("bc_we", 32'(we_block6), (k == 31) ? 32'd1 : 32'd0);
            step();
            #1;
        end
        check("bc_done", 32'(upd_done6), 32'd1);
        step();
        #1;
        check("bc_ready", 32'(upd_ready6), 32'd1);
`else
        check("bcast_ignored_err", 32'(upd_err6), 32'd1);
        check("bcast_ignored_busy", 32'(busy6), 32'd0);
        check("bcast_ignored_ce", 32'(ce6), 32'd0);
        step();
`endif

        // Reset at T+10 mid-SHIFT
        ce_demux8  = 8'h10;
        upd_valid8 = 1'b1;
        upd_blk8   = 3'd2;
        step();
        upd_valid8 = 1'b0;
        for (int k = 1; k < 10; k++) step();
        rst = 1'b1;
        #1;
        check("rst_mid_ce_T10", 32'(ce8), 32'h10);
        check("rst_mid_ready_T10", 32'(upd_ready8), 32'd0);
        step();
        #1;
        check("rst_mid_busy", 32'(busy8), 32'd0);
        check("rst_mid_ce", 32'(ce8), 32'h10);
        check("rst_mid_idx", 32'(shift_idx8), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            check("rst_mid_no_we", 32'(we_block8), 32'd0);
            check("rst_mid_no_done", 32'(upd_done8), 32'd0);
            check("rst_mid_idle_ce", 32'(ce8), 32'h10);
            step();
        end
        #1;
        check("rst_mid_ready", 32'(upd_ready8), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcam_update_ctrl.md
# tcam_update_ctrl

Parametrised update sequencer for the SRL-based TCAM array. It accepts one block-update request through a valid/ready handshake and drives that block's SRL clock-enable for exactly SRL_DEPTH shift cycles, presenting the bit index being shifted. It then pulses the block write-enable and a done strobe. It sits between the rule-update front end and the SRL blocks, and merges the search-path CE requests onto the same CE lines.

## Interface
Parameters:
- NUM_BLOCKS, 8: number of SRL blocks (≥2).
- SRL_DEPTH, 32: shift cycles per update (power of 2, ≥2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- upd_valid  in  1  update request.
- upd_ready  out  1  request accepted when upd_valid & upd_ready.
- upd_blk  in  BLK_W  target block index.
- upd_bcast  in  1  update all blocks at once (sampled only with TCAM_UPD_BCAST_EN).
- ce_demux  in  NUM_BLOCKS  search-path CE requests.
- ce  out  NUM_BLOCKS  SRL clock-enables.
- shift_idx  out  IDX_W  bit index currently shifted (0..SRL_DEPTH-1).
- busy  out  1  state ≠ IDLE.
- we_block  out  1  one-cycle commit pulse on the final shift cycle.
- upd_done  out  1  one-cycle completion pulse.
- upd_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - upd_ready=1.
  - On a handshake with upd_blk < NUM_BLOCKS: capture upd_mask = onehot(upd_blk), clear cnt, go to SHIFT.
  - On a handshake with upd_blk ≥ NUM_BLOCKS and no broadcast: pulse upd_err next cycle, stay in IDLE.
- SHIFT:
  - shift_idx=cnt, and cnt increments each cycle.
  - When cnt==SRL_DEPTH-1, assert we_block for that cycle and go to DONE.
- DONE: assert upd_done for one cycle, clear upd_mask, go to IDLE.
- ce = ce_demux | (upd_mask gated by state==SHIFT). ce_demux passes through combinationally in every state.
- cnt width is IDX_W. cnt never wraps, because the transition to DONE occurs at SRL_DEPTH-1.
- upd_blk is ignored outside the handshake cycle. upd_ready=0 in SHIFT and DONE, so requests presented there are held off and never dropped.

## Timing
- Handshake at cycle T.
  - SHIFT occupies T+1 … T+SRL_DEPTH, with shift_idx 0…SRL_DEPTH-1.
  - we_block is high at T+SRL_DEPTH.
  - upd_done is high at T+SRL_DEPTH+1.
  - upd_ready returns high at T+SRL_DEPTH+2.
- Throughput is one update per SRL_DEPTH+2 cycles.
- Reset values: state IDLE, upd_mask 0, cnt 0, shift_idx 0, busy 0, we_block 0, upd_done 0, upd_err 0. While rst is high, upd_ready is forced to 0 and ce equals ce_demux.
- Reset mid-SHIFT aborts immediately. No we_block or upd_done is issued, and the block contents are undefined until it is rewritten.
- upd_err is registered: it is high at T+1 for a rejected handshake at T.

## Configuration
- TCAM_UPD_BCAST_EN defined:
  - upd_bcast is honoured. A handshake with upd_bcast=1 loads upd_mask = all ones, regardless of upd_blk, and never raises upd_err.
  - Timing is identical to a single-block update.
- TCAM_UPD_BCAST_EN undefined: upd_bcast is ignored and only single-block updates exist.

## Structure
- The shared package tcam_pkg holds:
  - the FSM state enum;
  - the localparam functions BLK_W = max(1, clog2(NUM_BLOCKS)) and IDX_W = clog2(SRL_DEPTH).
- One sub-module, tcam_onehot_dec, is natural. It decodes upd_blk to a NUM_BLOCKS mask plus an out-of-range flag.
- The FSM, counter and CE merge stay in the top.

## Test plan
- Single update, NUM_BLOCKS=8, SRL_DEPTH=32:
  - Stimulus: handshake upd_blk=3 at T.
  - Response: ce[3]=1 for exactly 32 cycles with shift_idx 0..31, other ce bits 0, we_block at T+32, upd_done at T+33, upd_ready high at T+34.
- Search merge:
  - Stimulus: ce_demux=8'h81 during an update of block 3.
  - Response: ce=8'h89 throughout SHIFT; ce=8'h81 in IDLE and DONE, with zero latency.
- Back-to-back:
  - Stimulus: upd_valid held high with blk 1 then blk 6.
  - Response: second handshake exactly at T+34; no overlap of ce[1] and ce[6].
- Out-of-range:
  - Stimulus: NUM_BLOCKS=6, upd_blk=7.
  - Response: upd_err at T+1; busy stays 0; no ce and no we_block.
- Reset at T+10 mid-SHIFT:
  - Response: at T+11, ce equals ce_demux, busy=0, and we_block and upd_done never pulse.
- Broadcast (TCAM_UPD_BCAST_EN only):
  - Stimulus: upd_bcast=1, upd_blk=7, NUM_BLOCKS=6.
  - Response: ce=6'h3F for 32 cycles, no upd_err, we_block at T+32.
